// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer bank: FSM encoding and default widths.
package debounce_pkg;

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI   = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO   = 2'd3;

  localparam int DEF_CNT_W = 12;

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchroniser, edge-confirm FSM with countdown, registered pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int COUNT      = 4095,
  parameter int LONG_COUNT = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic press_nxt
);

  localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(COUNT);
  localparam logic [CNT_W-1:0] LONG_LD = CNT_W'(LONG_COUNT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0]       sync;
  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             lvl_n, rel_n, lp_n;
  logic             s;

  assign s = sync[1];

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lvl_n     = level;
    press_nxt = 1'b0;
    rel_n     = 1'b0;
    lp_n      = 1'b0;
    case (state)
      STABLE_LO: if (s) begin
        state_n = WAIT_HI;
        cnt_n   = CNT_LD;
      end
      WAIT_HI: begin
        if (!s) state_n = STABLE_LO;
        else if (cnt == ONE) begin
          state_n   = STABLE_HI;
          lvl_n     = 1'b1;
          press_nxt = 1'b1;
          cnt_n     = LONG_LD;
        end else cnt_n = cnt - ONE;
      end
      STABLE_HI: begin
        if (!s) begin
          state_n = WAIT_LO;
          cnt_n   = CNT_LD;
        end else if (LONG_COUNT != 0 && cnt == ONE) begin
          lp_n  = 1'b1;
          cnt_n = '0;
        end else if (cnt != '0) cnt_n = cnt - ONE;
      end
      WAIT_LO: begin
        // Bounce back high: counter parked at 0 so long_press cannot re-arm this hold.
        if (s) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
        end else if (cnt == ONE) begin
          state_n = STABLE_LO;
          lvl_n   = 1'b0;
          rel_n   = 1'b1;
        end else cnt_n = cnt - ONE;
      end
      default: state_n = STABLE_LO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync          <= '0;
      state         <= STABLE_LO;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      sync          <= {sync[0], raw};
      state         <= state_n;
      cnt           <= cnt_n;
      level         <= lvl_n;
      press         <= press_nxt;
      release_pulse <= rel_n;
      long_press    <= lp_n;
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent button debouncers plus a registered any-press summary.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int COUNT      = 4095,
  parameter int LONG_COUNT = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  // "release" is a reserved word, hence the suffix.
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press,
  output logic                any_press
);

  logic [CHANNELS-1:0] press_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .CNT_W     (CNT_W),
      .COUNT     (COUNT),
      .LONG_COUNT(LONG_COUNT)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .raw          (raw[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i]),
      .press_nxt    (press_nxt[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) any_press <= 1'b0;
    else        any_press <= |press_nxt;
  end

endmodule
